// File: rtl/div_arbiter.sv
// div_arbiter: round-robin arbiter sharing one divider between two requesters.
// Define DIV_ARBITER_ZERO_CHECK_EN to trap zero divisors without using the divider.
module div_arbiter #(
  parameter int WIDTH = 1025
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] q0,
  input  logic [WIDTH-1:0] q1,
  input  logic [WIDTH-1:0] m0,
  input  logic [WIDTH-1:0] m1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] quot0,
  output logic [WIDTH-1:0] quot1,
  output logic [WIDTH-1:0] rem0,
  output logic [WIDTH-1:0] rem1,
  output logic             err0,
  output logic             err1,
  output logic             busy,
  output logic             div_start,
  output logic [WIDTH-1:0] div_q,
  output logic [WIDTH-1:0] div_m,
  input  logic             div_done,
  input  logic [WIDTH-1:0] div_quot,
  input  logic [WIDTH-1:0] div_rem
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t           r_state;
  logic             r_owner, r_last, r_start;
  logic [1:0]       r_done, r_err;
  logic [WIDTH-1:0] r_q, r_m;
  logic [WIDTH-1:0] r_quot [2];
  logic [WIDTH-1:0] r_rem [2];
  logic             w_win, w_trap;
  logic [WIDTH-1:0] w_q, w_m;
  // on a tie the requester not served last wins
  assign w_win = (req0 & req1) ? ~r_last : req1;
  assign w_q   = w_win ? q1 : q0;
  assign w_m   = w_win ? m1 : m0;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
  assign w_trap = ~|w_m;
`else
  assign w_trap = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
      r_start <= 1'b0;
      r_done  <= '0;
      r_err   <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_quot  <= '{default: '0};
      r_rem   <= '{default: '0};
    end else begin
      case (r_state)
        IDLE: if (req0 | req1) begin
          r_owner <= w_win;
          r_q     <= w_q;
          r_m     <= w_m;
          if (w_trap) begin
            r_quot[w_win] <= '1;
            r_rem[w_win]  <= w_q;
            r_err[w_win]  <= 1'b1;
            r_done[w_win] <= 1'b1;
            r_state       <= RESP;
          end else begin
            r_start <= 1'b1;
            r_state <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_start <= 1'b0;
          r_state <= WAIT;
        end
        WAIT: if (div_done) begin
          r_quot[r_owner] <= div_quot;
          r_rem[r_owner]  <= div_rem;
          r_err[r_owner]  <= 1'b0;
          r_done[r_owner] <= 1'b1;
          r_state         <= RESP;
        end
        RESP: begin
          r_done  <= '0;
          r_last  <= r_owner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign busy      = r_state != IDLE;
  assign div_start = r_start;
  assign div_q     = r_q;
  assign div_m     = r_m;
  assign done0     = r_done[0];
  assign done1     = r_done[1];
  assign err0      = r_err[0];
  assign err1      = r_err[1];
  assign quot0     = r_quot[0];
  assign quot1     = r_quot[1];
  assign rem0      = r_rem[0];
  assign rem1      = r_rem[1];
endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed vectors, corner sequences and random traffic for div_arbiter
// against a transaction-level model of grant order and division results.
module tb_div_arbiter;
  localparam int W = 1025;
`ifdef DIV_ARBITER_ZERO_CHECK_EN
  localparam bit ZC = 1'b1;
`else
  localparam bit ZC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, req0, req1, div_done;
  logic [W-1:0] q0, q1, m0, m1, div_quot, div_rem;
  logic done0, done1, err0, err1, busy, div_start;
  logic [W-1:0] quot0, quot1, rem0, rem1, div_q, div_m;

  div_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .q0(q0), .q1(q1), .m0(m0), .m1(m1),
    .done0(done0), .done1(done1), .quot0(quot0), .quot1(quot1), .rem0(rem0), .rem1(rem1),
    .err0(err0), .err1(err1), .busy(busy), .div_start(div_start), .div_q(div_q), .div_m(div_m),
    .div_done(div_done), .div_quot(div_quot), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  // divider stand-in: answers dv_lat cycles after seeing div_start; stale_req forces a spurious done
  int dv_lat = 2, stale_req = 0, n_start = 0, dv_cnt = 0, dv_seen = 0;
  logic [W-1:0] dv_a, dv_b;
  initial begin
    div_done = 1'b0;
    div_quot = '0;
    div_rem  = '0;
    forever begin
      @(negedge clk);
      div_done = 1'b0;
      if (dv_cnt > 0) begin
        dv_cnt--;
        if (dv_cnt == 0) begin
          div_done = 1'b1;
          if (dv_b == '0) begin div_quot = '1; div_rem = dv_a; end
          else begin div_quot = dv_a / dv_b; div_rem = dv_a % dv_b; end
        end
      end
      if (stale_req != dv_seen) begin
        dv_seen  = stale_req;
        div_done = 1'b1;
        div_quot = '1;
        div_rem  = '1;
      end
      if (div_start) begin
        n_start++;
        dv_a   = div_q;
        dv_b   = div_m;
        dv_cnt = dv_lat;
      end
    end
  end

  // transaction-level model: held results per requester and last-served pointer
  logic [W-1:0] mq [2];
  logic [W-1:0] mr [2];
  bit me [2];
  int mlast;
  function automatic void mdl_reset();
    for (int i = 0; i < 2; i++) begin mq[i] = '0; mr[i] = '0; me[i] = 1'b0; end
    mlast = 1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done0 | done1) begin ok = 1'b1; break; end
    end
    chk("done_timeout", {31'd0, ok}, 1);
  endtask

  // called at a negedge where a done pulse is visible; checks it against the model
  task automatic serve(input int o, input logic [W-1:0] x, input logic [W-1:0] y, input int s0);
    bit trap;
    trap = ZC && (y == '0);
    chk("done_owner", {done1, done0}, (o == 1) ? 2'd2 : 2'd1);
    chk("busy_resp", busy, 1);
    if (y == '0) begin mq[o] = '1; mr[o] = x; end
    else begin mq[o] = x / y; mr[o] = x % y; end
    me[o] = trap;
    mlast = o;
    chk("quot0", quot0, mq[0]);
    chk("rem0", rem0, mr[0]);
    chk("err0", err0, me[0]);
    chk("quot1", quot1, mq[1]);
    chk("rem1", rem1, mr[1]);
    chk("err1", err1, me[1]);
    chk("start_count", n_start - s0, trap ? 0 : 1);
  endtask

  task automatic run_txn(input bit a0, input bit a1, input logic [W-1:0] x0, input logic [W-1:0] y0,
                         input logic [W-1:0] x1, input logic [W-1:0] y1);
    bit p0, p1, ok;
    int o, s0;
    @(negedge clk);
    q0 = x0; m0 = y0; q1 = x1; m1 = y1;
    req0 = a0; req1 = a1; p0 = a0; p1 = a1;
    while (p0 | p1) begin
      o  = (p0 && p1) ? 1 - mlast : (p1 ? 1 : 0);
      s0 = n_start;
      wait_done(ok);
      if (!ok) begin do_reset(); return; end
      serve(o, (o == 1) ? x1 : x0, (o == 1) ? y1 : y0, s0);
      if (o == 1) begin req1 = 1'b0; p1 = 1'b0; end
      else begin req0 = 1'b0; p0 = 1'b0; end
      @(negedge clk);
      chk("done_pulse", {done1, done0}, 0);
    end
  endtask

  function automatic logic [W-1:0] rnd_w(input int bits);
    logic [1055:0] v;
    for (int i = 0; i < 1056; i += 32) v[i+:32] = $urandom;
    return v[W-1:0] & ({W{1'b1}} >> (W - bits));
  endfunction

  typedef struct {
    bit a0, a1;
    logic [W-1:0] x0, y0, x1, y1, eq0, er0, eq1, er1;
    bit ee0, ee1;
  } vec_t;
  vec_t vt [5];
  logic [W-1:0] ones;

  initial begin
    bit ok, seen;
    int s0;
    ones = '1;
    vt[0] = '{1, 1, 50, 5, 9, 4, 10, 0, 2, 1, 0, 0};
    vt[1] = '{0, 1, 0, 0, 33, 0, 10, 0, ones, 33, 0, ZC};
    vt[2] = '{1, 0, 1000, 10, 0, 0, 100, 0, ones, 33, 0, ZC};
    vt[3] = '{1, 1, 7, 9, 1000, 1, 0, 7, 1000, 0, 0, 0};
    vt[4] = '{1, 0, 5, 0, 0, 0, ones, 5, 1000, 0, ZC, 0};
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    q0 = '0; q1 = '0; m0 = '0; m1 = '0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_start", div_start, 0);
    chk("rst_done", {done1, done0}, 0);
    chk("rst_err", {err1, err0}, 0);
    chk("rst_quot0", quot0, 0);
    chk("rst_quot1", quot1, 0);
    chk("rst_rem0", rem0, 0);
    chk("rst_rem1", rem1, 0);
    chk("rst_div_q", div_q, 0);
    chk("rst_div_m", div_m, 0);
    rst = 1'b0;
    mdl_reset();

    // single request, latency of start and done
    dv_lat = 3;
    s0 = n_start;
    @(negedge clk);
    q0 = 100; m0 = 7; req0 = 1'b1;
    @(negedge clk);
    chk("lat_start_k1", div_start, 1);
    chk("lat_div_q", div_q, 100);
    chk("lat_div_m", div_m, 7);
    chk("lat_busy", busy, 1);
    @(negedge clk);
    chk("lat_start_once", div_start, 0);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      if (div_done) begin ok = 1'b1; break; end
    end
    chk("lat_div_done_seen", {31'd0, ok}, 1);
    @(negedge clk);
    chk("lat_done_next", done0, 1);
    serve(0, 100, 7, s0);
    req0 = 1'b0;
    @(negedge clk);
    chk("lat_done_pulse", done0, 0);

    // directed table
    do_reset();
    dv_lat = 2;
    for (int i = 0; i < 5; i++) begin
      run_txn(vt[i].a0, vt[i].a1, vt[i].x0, vt[i].y0, vt[i].x1, vt[i].y1);
      chk($sformatf("vec%0d_quot0", i), quot0, vt[i].eq0);
      chk($sformatf("vec%0d_rem0", i), rem0, vt[i].er0);
      chk($sformatf("vec%0d_quot1", i), quot1, vt[i].eq1);
      chk($sformatf("vec%0d_rem1", i), rem1, vt[i].er1);
      chk($sformatf("vec%0d_err", i), {err1, err0}, {vt[i].ee1, vt[i].ee0});
    end

    // both requests held over four grants
    do_reset();
    @(negedge clk);
    q0 = 77; m0 = 6; q1 = 500; m1 = 13; req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0 = n_start;
      wait_done(ok);
      if (!ok) break;
      serve(i % 2, (i % 2 == 1) ? q1 : q0, (i % 2 == 1) ? m1 : m0, s0);
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      chk("hold_done_pulse", {done1, done0}, 0);
    end
    req0 = 1'b0; req1 = 1'b0;

    // reset while waiting on the divider, then stale div_done
    dv_lat = 20;
    @(negedge clk);
    q0 = 91; m0 = 3; req0 = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (div_start) begin ok = 1'b1; break; end
    end
    chk("wr_start_seen", {31'd0, ok}, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("wr_busy", busy, 0);
    chk("wr_done", {done1, done0}, 0);
    chk("wr_start", div_start, 0);
    chk("wr_quot0", quot0, 0);
    chk("wr_rem1", rem1, 0);
    chk("wr_div_q", div_q, 0);
    req0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mdl_reset();
    s0 = n_start;
    stale_req++;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done0 | done1 | busy) seen = 1'b1;
    end
    chk("wr_stale_ignored", {31'd0, seen}, 0);
    chk("wr_no_start", n_start - s0, 0);
    chk("wr_quot0_zero", quot0, 0);
    dv_lat = 2;
    run_txn(0, 1, 0, 0, 9, 4);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      int msk, bx, by;
      msk    = $urandom_range(1, 3);
      dv_lat = $urandom_range(1, 6);
      bx     = ($urandom_range(0, 1) == 1) ? W : $urandom_range(1, 64);
      by     = $urandom_range(1, 40);
      run_txn(msk[0], msk[1], rnd_w(bx),
              ($urandom_range(0, 4) == 0) ? '0 : rnd_w(by),
              rnd_w($urandom_range(1, W)),
              ($urandom_range(0, 4) == 0) ? '0 : rnd_w(by));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 1025, giving the operand and result width of the shared divider.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports req0/req1  input  1 each  level request from requester 0/1.
REQ-005 SHALL have ports q0/q1  input  WIDTH each  dividend of requester 0/1.
REQ-006 SHALL have ports m0/m1  input  WIDTH each  divisor of requester 0/1.
REQ-007 SHALL have ports done0/done1  output  1 each  one-cycle result-valid pulse to requester 0/1.
REQ-008 SHALL have ports quot0/quot1  output  WIDTH each  registered quotient for requester 0/1.
REQ-009 SHALL have ports rem0/rem1  output  WIDTH each  registered remainder for requester 0/1.
REQ-010 SHALL have ports err0/err1  output  1 each  divide-by-zero flag, valid with doneN.
REQ-011 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL have ports div_start, div_q, div_m  output  1/WIDTH/WIDTH  divider start pulse and operands.
REQ-013 SHALL have ports div_done, div_quot, div_rem  input  1/WIDTH/WIDTH  divider completion and results.

Function
REQ-014 SHALL implement FSM states IDLE, LAUNCH, WAIT, RESP.
REQ-015 SHALL sample req0/req1 only in IDLE; all other states ignore them.
REQ-016 In IDLE, a single request SHALL be granted; on simultaneous requests, the requester not served last SHALL win (round-robin).
REQ-017 On grant, SHALL latch the winner's q/m into div_q/div_m, record the owner, and move to LAUNCH.
REQ-018 In LAUNCH, SHALL drive div_start high for exactly one cycle, then move to WAIT.
REQ-019 In WAIT, div_start SHALL be low; on div_done=1, SHALL copy div_quot/div_rem into the owner's quot/rem and move to RESP.
REQ-020 In RESP, SHALL pulse the owner's doneN for one cycle, update the last-served pointer to the owner, and return to IDLE.
REQ-021 The non-owner's quot/rem/err/done SHALL remain unchanged throughout the transaction.
REQ-022 Results SHALL hold until that requester's next RESP.
REQ-023 A requester SHALL keep operands stable until grant and deassert req in the cycle after its doneN.
REQ-024 Latency SHALL be: req sampled at edge k, div_start high in cycle k+1, doneN high in the cycle after div_done is sampled.
REQ-025 div_done SHALL be ignored outside WAIT.
REQ-026 No timeout SHALL be applied; WAIT persists until div_done.

Reset
REQ-027 rst SHALL immediately force IDLE, with div_start, done0/1, err0/1, busy=0 and div_q, div_m, quot0/1, rem0/1=0.
REQ-028 rst SHALL set the last-served pointer to 1, so requester 0 wins the first tie.
REQ-029 Reset during LAUNCH/WAIT SHALL abandon the transaction with no doneN.
REQ-030 A stale div_done after such a reset SHALL be ignored because the FSM is in IDLE.

Configuration
REQ-031 Macro DIV_ARBITER_ZERO_CHECK_EN SHALL control divide-by-zero trapping.
REQ-032 With DIV_ARBITER_ZERO_CHECK_EN defined, a granted divisor of 0 SHALL skip LAUNCH/WAIT and go directly to RESP, never asserting div_start.
REQ-033 In that zero-divisor case: quot=all ones, rem=dividend, errN=1 with doneN.
REQ-034 errN SHALL be 0 on every nonzero-divisor transaction.
REQ-035 Without the macro, err0/err1 SHALL be tied 0, and a zero divisor SHALL go to the divider unchecked.

Verification
REQ-036 Scenario: req0, q0=100, m0=7 -> one div_start pulse, then done0 with quot0=14, rem0=2, err0=0; quot1/rem1 stay 0.
REQ-037 Scenario: after reset, req0 and req1 asserted in the same cycle (q0=50,m0=5; q1=9,m1=4) -> requester 0 is served first (quot0=10, rem0=0), then requester 1 (quot1=2, rem1=1).
REQ-038 Scenario: both requests held continuously over four transactions -> grants alternate 0,1,0,1, with exactly one div_start per grant.
REQ-039 Scenario: rst asserted in WAIT, then div_done pulses -> no doneN, busy=0, outputs zero; a new req1 is then granted normally.
REQ-040 Scenario: req1 with m1=0, q1=33, macro defined -> no div_start, done1 with quot1=all ones, rem1=33, err1=1; without the macro, div_start fires and err1=0.
